// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: widths, ALU op codes, FSM states, op classifiers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 8;

    localparam logic [ALUOP_W-1:0] OP_NOP = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] OP_OR  = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] OP_LB  = 8'b1110_0000;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'b1110_0001;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'b1110_0011;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'b1110_1000;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'b1110_1001;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Word ops need addr[1:0] == 0, halfword ops need addr[0] == 0.
    function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op, input logic [1:0] lo);
        return (((op == OP_LW) || (op == OP_SW)) && (lo != 2'b00)) ||
               (((op == OP_LH) || (op == OP_SH)) && lo[0]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables/replicated write data, load extraction with sign extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        reg2,
    input  logic [31:0]        rdata,
    output logic [3:0]         be,
    output logic [31:0]        st_data,
    output logic [31:0]        ld_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Byte enables and store data replicated onto every lane the access may hit.
    always_comb begin
        be      = 4'b1111;
        st_data = reg2;
        case (aluop)
            OP_SH: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{reg2[15:0]}};
            end
            OP_SB: begin
                be      = 4'b0001 << addr_lo;
                st_data = {4{reg2[7:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane(s) out of the little-endian word and sign-extend.
    always_comb begin
        sel_byte = rdata[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (aluop)
            OP_LB:   ld_data = {{24{sel_byte[7]}}, sel_byte};
            OP_LH:   ld_data = {{16{sel_half[15]}}, sel_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data bus loads/stores, stalls the pipeline until the transfer finishes.
// Latency: memory ops take ack latency + 1 cycles (min 2); other ops pass through in 0 cycles.
// Backpressure: stallreq_o held while a memory op is awaiting ack; optional MEM_STAGE_ALIGN_CHECK_EN adds misalign_o.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [REG_W-1:0]   wd_i,
    input  logic               wreg_i,
    input  logic [DATA_W-1:0]  wdata_i,
    input  logic [DATA_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  logic [DATA_W-1:0]  pc_i,
    output logic [REG_W-1:0]   wd_o,
    output logic               wreg_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic [DATA_W-1:0]  pc_o,
    output logic               stallreq_o,
    output logic               dbus_req_o,
    output logic               dbus_we_o,
    output logic [3:0]         dbus_be_o,
    output logic [DATA_W-1:0]  dbus_addr_o,
    output logic [DATA_W-1:0]  dbus_wdata_o,
    input  logic [DATA_W-1:0]  dbus_rdata_i,
    input  logic               dbus_ack_i
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic               misalign_o
`endif
);

    mem_state_t  state;
    logic [31:0] load_q;
    logic        mem_op;
    logic        store_op;
    logic        misaligned;
    logic        active;
    logic        bus_phase;
    logic [3:0]  be_w;
    logic [31:0] st_data_w;
    logic [31:0] ld_data_w;

    assign mem_op   = is_mem_op(aluop_i);
    assign store_op = is_store_op(aluop_i);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned = mem_op && is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign misalign_o = misaligned && !rst;
`else
    assign misaligned = 1'b0;
`endif

    // A memory op that will actually touch the bus; bus_phase covers IDLE and WAIT.
    assign active    = mem_op && !misaligned && !rst;
    assign bus_phase = active && (state != ST_DONE);

    mem_lane_align u_lane (
        .aluop   (aluop_i),
        .addr_lo (mem_addr_i[1:0]),
        .reg2    (reg2_i),
        .rdata   (dbus_rdata_i),
        .be      (be_w),
        .st_data (st_data_w),
        .ld_data (ld_data_w)
    );

    // Transfer FSM plus load capture on the ack edge; ack outside a request is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            load_q <= '0;
        end else begin
            if (bus_phase && dbus_ack_i && !store_op)
                load_q <= ld_data_w;
            case (state)
                ST_IDLE: if (active) state <= dbus_ack_i ? ST_DONE : ST_WAIT;
                ST_WAIT: begin
                    if (!active)
                        state <= ST_IDLE;
                    else if (dbus_ack_i)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus side: inputs are frozen by the stall, so these stay stable through WAIT.
    assign dbus_req_o   = bus_phase;
    assign dbus_we_o    = bus_phase && store_op;
    assign dbus_be_o    = bus_phase ? be_w : 4'b0000;
    assign dbus_addr_o  = bus_phase ? {mem_addr_i[31:2], 2'b00} : '0;
    assign dbus_wdata_o = (bus_phase && store_op) ? st_data_w : '0;
    assign stallreq_o   = bus_phase;

    // Writeback side: loads deliver the captured word in DONE; stores never write a register.
    assign wd_o    = rst ? '0 : wd_i;
    assign pc_o    = rst ? '0 : pc_i;
    assign wreg_o  = !rst && wreg_i && !store_op && !misaligned;
    assign wdata_o = rst ? '0 :
                     (mem_op && !store_op && (state == ST_DONE)) ? load_q : wdata_i;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level reference model and literal spot checks.
// Latency: n/a (bench).
// Backpressure: bench acks after a chosen number of wait cycles.
module tb_mem_stage;
    import mem_stage_pkg::*;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, pc_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, pc_o;
    logic        stallreq_o, dbus_req_o, dbus_we_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
    logic        dbus_ack_i;
    logic        misalign_o;

    mem_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o),
        .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_be_o(dbus_be_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        , .misalign_o(misalign_o)
`endif
    );

`ifndef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Expected values for the current cycle, published by the driver.
    logic        chk_en = 1'b0;
    logic        exp_req, exp_we, exp_stall, exp_wreg, exp_wchk, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_bwd, exp_wdata, exp_pc;
    logic [4:0]  exp_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic set_exp(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] bwd, input logic stall,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic wchk, input logic [31:0] pc, input logic mis);
        exp_req = req; exp_we = we; exp_be = be; exp_addr = addr; exp_bwd = bwd;
        exp_stall = stall; exp_wd = wd; exp_wreg = wreg; exp_wdata = wdata;
        exp_wchk = wchk; exp_pc = pc; exp_mis = mis; chk_en = 1'b1;
    endtask

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stallreq_o}, {31'd0, exp_stall});
            chk("req", {31'd0, dbus_req_o}, {31'd0, exp_req});
            if (exp_req) begin
                chk("we", {31'd0, dbus_we_o}, {31'd0, exp_we});
                chk("be", {28'd0, dbus_be_o}, {28'd0, exp_be});
                chk("baddr", dbus_addr_o, exp_addr);
                if (exp_we) chk("bwdata", dbus_wdata_o, exp_bwd);
            end
            chk("wd", {27'd0, wd_o}, {27'd0, exp_wd});
            chk("wreg", {31'd0, wreg_o}, {31'd0, exp_wreg});
            chk("pc", pc_o, exp_pc);
            if (exp_wchk) chk("wdata", wdata_o, exp_wdata);
            if (ALIGN_CHK) chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
        end
    end

    function automatic bit m_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit m_load(input logic [7:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW;
    endfunction

    function automatic bit m_mis(input logic [7:0] op, input logic [31:0] a);
        if (!ALIGN_CHK) return 1'b0;
        if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
        if (op == OP_LH || op == OP_SH) return (a % 2) != 0;
        return 1'b0;
    endfunction

    // Loaded value from the word: shift the addressed lane down, then sign-extend arithmetically.
    function automatic logic [31:0] m_load_val(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        if (op == OP_LB) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            return (v ^ 32'h80) - 32'h80;
        end
        if (op == OP_LH) begin
            v = (rd >> (((a / 2) % 2) * 16)) & 32'hFFFF;
            return (v ^ 32'h8000) - 32'h8000;
        end
        return rd;
    endfunction

    // One instruction in MEM, from entry to the edge it leaves; lat = cycles before ack.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] wdi, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] pc, input logic [31:0] rdata, input int lat,
                          input bit lit_en, input logic [31:0] lit_val);
        bit st, ld, mis;
        logic [3:0]  be;
        logic [31:0] bwd, res;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdi;
        wd_i = wd; wreg_i = wreg; pc_i = pc;
        st  = m_store(op);
        ld  = m_load(op);
        mis = m_mis(op, addr) && (st || ld);
        if (!(st || ld) || mis) begin
            dbus_ack_i   = 1'($urandom_range(0, 1));
            dbus_rdata_i = $urandom;
            set_exp(0, 0, 4'h0, 0, 0, 0, wd, wreg && !st && !mis, wdi, 1, pc, mis);
            @(posedge clk); #1;
        end else begin
            if (op == OP_SB) begin
                be  = 4'(1 << (addr % 4));
                bwd = (reg2 & 32'hFF) * 32'h0101_0101;
            end else if (op == OP_SH) begin
                be  = ((addr / 2) % 2) ? 4'b1100 : 4'b0011;
                bwd = (reg2 & 32'hFFFF) * 32'h0001_0001;
            end else begin
                be  = 4'b1111;
                bwd = reg2;
            end
            for (int c = 0; c <= lat; c++) begin
                dbus_ack_i   = (c == lat);
                dbus_rdata_i = (c == lat) ? rdata : $urandom;
                set_exp(1, st, be, addr & 32'hFFFF_FFFC, bwd, 1, wd, wreg && !st, 0, 0, pc, 0);
                @(posedge clk); #1;
            end
            dbus_ack_i   = 1'($urandom_range(0, 1));
            dbus_rdata_i = $urandom;
            res = ld ? (lit_en ? lit_val : m_load_val(op, addr, rdata)) : wdi;
            set_exp(0, 0, 4'h0, 0, 0, 0, wd, wreg && !st, res, 1, pc, 0);
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] op_tab [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_tab = '{OP_NOP, OP_OR, OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW};
        rst = 1'b1;
        aluop_i = OP_OR; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h5555_AAAA;
        mem_addr_i = 32'h100; reg2_i = 32'h1; pc_i = 32'h400; dbus_rdata_i = 0; dbus_ack_i = 1'b0;
        @(posedge clk); #1;
        // Reset state: everything quiet while rst is high.
        set_exp(0, 0, 4'h0, 0, 0, 0, 5'd0, 0, 32'd0, 1, 32'd0, 0);
        @(posedge clk); #1;
        aluop_i = OP_LW;
        @(posedge clk); #1;
        rst = 1'b0;

        // Literal cases.
        run_op(OP_LW, 32'h100, 0, 32'h1111, 5'd3, 1, 32'h1000, 32'h89AB_CDEF, 0, 1, 32'h89AB_CDEF);
        run_op(OP_LB, 32'h103, 0, 32'h2222, 5'd4, 1, 32'h1004, 32'h80FF_1234, 3, 1, 32'hFFFF_FF80);
        run_op(OP_LH, 32'h102, 0, 32'h3333, 5'd5, 1, 32'h1008, 32'h7FFF_0000, 1, 1, 32'h0000_7FFF);

        // SB literal bus check, done by hand in the request cycle.
        chk_en = 1'b0;
        aluop_i = OP_SB; mem_addr_i = 32'h101; reg2_i = 32'h0000_00AB; wreg_i = 1'b1;
        dbus_ack_i = 1'b1;
        @(negedge clk);
        chk("sb_be", {28'd0, dbus_be_o}, 32'h2);
        chk("sb_wdata", dbus_wdata_o, 32'hABAB_ABAB);
        chk("sb_we", {31'd0, dbus_we_o}, 32'h1);
        chk("sb_wreg", {31'd0, wreg_o}, 32'h0);
        @(posedge clk); #1;
        dbus_ack_i = 1'b0;
        @(negedge clk);
        chk("sb_done_req", {31'd0, dbus_req_o}, 32'h0);
        chk("sb_done_stall", {31'd0, stallreq_o}, 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of a SW wait, then a stray ack.
        aluop_i = OP_SW; mem_addr_i = 32'h200; reg2_i = 32'hDEAD_BEEF; wd_i = 5'd9;
        wreg_i = 1'b1; pc_i = 32'h2000; wdata_i = 32'h0; dbus_ack_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_exp(1, 1, 4'hF, 32'h200, 32'hDEAD_BEEF, 1, 5'd9, 0, 0, 0, 32'h2000, 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        set_exp(0, 0, 4'h0, 0, 0, 0, 5'd0, 0, 32'd0, 1, 32'd0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        aluop_i = OP_OR; wdata_i = 32'h0000_1234; wd_i = 5'd2; wreg_i = 1'b1; pc_i = 32'h2004;
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
        set_exp(0, 0, 4'h0, 0, 0, 0, 5'd2, 1, 32'h0000_1234, 1, 32'h2004, 0);
        @(posedge clk); #1;
        run_op(OP_LW, 32'h300, 0, 32'h0, 5'd6, 1, 32'h2008, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D);

        // Misaligned word load (flagged only with the alignment check) and ORI pass-through.
        run_op(OP_LW, 32'h102, 0, 32'h4444, 5'd8, 1, 32'h3000, 32'hCAFE_BABE, 1, 0, 0);
        run_op(OP_OR, 32'h0, 0, 32'h0000_1234, 5'd1, 1, 32'h3004, 0, 0, 0, 0);

        // Randomized instruction stream with back-to-back memory ops.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] op;
            op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 7)];
            run_op(op, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom_range(0, 3), 0, 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
